// File: rtl/def_muxs.sv
`default_nettype none
// ============================================================================
//  Module      : def_muxs (package)
//  Description : Write-back source select codes and small helpers shared by
//                the write-back pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
package def_muxs;

    // Width of the write-back source select field
    localparam int unsigned c_sel_w = 2;

    // Write-back source select codes carried with every instruction
    typedef enum logic [c_sel_w-1:0] {
        WRREG_ALURESULT = 2'b00,
        WRREG_IMMDATA   = 2'b01,
        WRREG_DMDATA    = 2'b10,
        WRREG_PCPLUS    = 2'b11
    } wrreg_sel_e;

    // A bubble enters EX when it is not frozen and either a taken branch
    // kills the incoming instruction or a load-use hazard must be covered.
    function automatic logic ex_bubble(input logic stall,
                                       input logic flush,
                                       input logic hazard);
        return ~stall & (flush | hazard);
    endfunction

    // The hazard counter only moves on cycles where the hazard itself is
    // the reason for the bubble; a stall or a flush masks it.
    function automatic logic hazard_counts(input logic stall,
                                           input logic flush,
                                           input logic hazard);
        return ~stall & ~flush & hazard;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage_reg
//  Description : One pipeline stage register. Holds on i_hold, loads a
//                bubble (all fields zero) on i_bubble, otherwise loads the
//                incoming control and data fields.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_stage_reg
    import def_muxs::*;
#(
    parameter int unsigned CTRL_W = 1,
    parameter int unsigned DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst,        // asynchronous, active-low
    input  logic              i_hold,
    input  logic              i_bubble,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic [CTRL_W-1:0] r_ctrl_q;
    logic [CTRL_W-1:0] w_ctrl_d;
    logic [DATA_W-1:0] r_data_q;
    logic [DATA_W-1:0] w_data_d;

    // Next-state selection: hold has priority over bubble, bubble over load.
    // Data is also cleared on a bubble so dead slots never carry stale values.
    always_comb begin
        w_ctrl_d = r_ctrl_q;
        w_data_d = r_data_q;
        if (i_hold) begin
            w_ctrl_d = r_ctrl_q;
            w_data_d = r_data_q;
        end else if (i_bubble) begin
            w_ctrl_d = '0;
            w_data_d = '0;
        end else begin
            w_ctrl_d = i_ctrl;
            w_data_d = i_data;
        end
    end

    // Stage state, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ctrl_q <= '0;
            r_data_q <= '0;
        end else begin
            r_ctrl_q <= w_ctrl_d;
            r_data_q <= w_data_d;
        end
    end

    assign o_ctrl = r_ctrl_q;
    assign o_data = r_data_q;

endmodule
`default_nettype wire

// File: rtl/wb_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pipe
//  Description : Destination-write pipeline from decode through EX (xREG2),
//                MEM (xREG3) and WB (xREG4). Builds the MEM write-back value,
//                drives the register-file write port, injects load-use and
//                flush bubbles into EX and counts hazard bubbles.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_pipe
    import def_muxs::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst,                 // asynchronous, active-low
    input  logic          id_do_reg_write,
    input  logic          id_do_dm_read,
    input  logic [1:0]    id_select_write_reg,
    input  logic [AW-1:0] id_write_reg_addr,
    input  logic [DW-1:0] id_imm_extend,
    input  logic [DW-1:0] alu_result,
    input  logic [DW-1:0] dm_read_data,
    input  logic [DW-1:0] pc_plus,
    input  logic          do_hazard,
    input  logic          flush,
    input  logic          mem_stall,
    output logic          id_hold,
    output logic          xREG2_do_reg_write,
    output logic          xREG2_do_dm_read,
    output logic [1:0]    xREG2_select_write_reg,
    output logic [AW-1:0] xREG2_write_reg_addr,
    output logic [DW-1:0] xREG2_imm_extend,
    output logic          xREG3_do_reg_write,
    output logic [AW-1:0] xREG3_write_reg_addr,
    output logic [DW-1:0] write_reg_data,
    output logic          xREG4_do_reg_write,
    output logic [AW-1:0] xREG4_write_reg_addr,
    output logic [DW-1:0] xREG4_write_reg_data,
    output logic [CW-1:0] hazard_cnt
);

    // Packed stage payload widths
    localparam int unsigned c_x2_ctrl_w = 2;
    localparam int unsigned c_x2_data_w = c_sel_w + AW + 2 * DW;
    localparam int unsigned c_x3_ctrl_w = 1;
    localparam int unsigned c_x3_data_w = c_sel_w + AW + 3 * DW;
    localparam int unsigned c_x4_ctrl_w = 1;
    localparam int unsigned c_x4_data_w = AW + DW;

    // ------------------------------------------------------------------
    // Stage control
    // ------------------------------------------------------------------
    logic w_freeze;
    logic w_x2_bubble;
    logic w_hazard_inc;

    assign w_freeze     = mem_stall;
    assign w_x2_bubble  = ex_bubble(mem_stall, flush, do_hazard);
    assign w_hazard_inc = hazard_counts(mem_stall, flush, do_hazard);

    // Decode re-presents its instruction on a freeze or an unflushed hazard
    assign id_hold = mem_stall | (do_hazard & ~flush);

    // ------------------------------------------------------------------
    // xREG2 : EX stage
    // ------------------------------------------------------------------
    logic [c_x2_ctrl_w-1:0] w_x2_ctrl_in;
    logic [c_x2_data_w-1:0] w_x2_data_in;
    logic [c_x2_ctrl_w-1:0] w_x2_ctrl;
    logic [c_x2_data_w-1:0] w_x2_data;
    logic [DW-1:0]          w_x2_pc;

    assign w_x2_ctrl_in = {id_do_reg_write, id_do_dm_read};
    assign w_x2_data_in = {id_select_write_reg, id_write_reg_addr,
                           id_imm_extend, pc_plus};

    wb_stage_reg #(
        .CTRL_W (c_x2_ctrl_w),
        .DATA_W (c_x2_data_w)
    ) u_xreg2 (
        .clk      (clk),
        .rst      (rst),
        .i_hold   (w_freeze),
        .i_bubble (w_x2_bubble),
        .i_ctrl   (w_x2_ctrl_in),
        .i_data   (w_x2_data_in),
        .o_ctrl   (w_x2_ctrl),
        .o_data   (w_x2_data)
    );

    assign {xREG2_do_reg_write, xREG2_do_dm_read} = w_x2_ctrl;
    assign {xREG2_select_write_reg, xREG2_write_reg_addr,
            xREG2_imm_extend, w_x2_pc}            = w_x2_data;

    // ------------------------------------------------------------------
    // xREG3 : MEM stage (never receives a bubble of its own)
    // ------------------------------------------------------------------
    logic [c_x3_ctrl_w-1:0] w_x3_ctrl_in;
    logic [c_x3_data_w-1:0] w_x3_data_in;
    logic [c_x3_ctrl_w-1:0] w_x3_ctrl;
    logic [c_x3_data_w-1:0] w_x3_data;
    logic [c_sel_w-1:0]     w_x3_sel;
    logic [DW-1:0]          w_x3_alu;
    logic [DW-1:0]          w_x3_imm;
    logic [DW-1:0]          w_x3_pc;

    assign w_x3_ctrl_in = xREG2_do_reg_write;
    assign w_x3_data_in = {xREG2_select_write_reg, xREG2_write_reg_addr,
                           alu_result, xREG2_imm_extend, w_x2_pc};

    wb_stage_reg #(
        .CTRL_W (c_x3_ctrl_w),
        .DATA_W (c_x3_data_w)
    ) u_xreg3 (
        .clk      (clk),
        .rst      (rst),
        .i_hold   (w_freeze),
        .i_bubble (1'b0),
        .i_ctrl   (w_x3_ctrl_in),
        .i_data   (w_x3_data_in),
        .o_ctrl   (w_x3_ctrl),
        .o_data   (w_x3_data)
    );

    assign xREG3_do_reg_write = w_x3_ctrl[0];
    assign {w_x3_sel, xREG3_write_reg_addr,
            w_x3_alu, w_x3_imm, w_x3_pc} = w_x3_data;

    // MEM-stage write-back source mux; load data comes straight from memory
    always_comb begin
        write_reg_data = w_x3_alu;
        case (w_x3_sel)
            WRREG_ALURESULT: write_reg_data = w_x3_alu;
            WRREG_IMMDATA:   write_reg_data = w_x3_imm;
            WRREG_DMDATA:    write_reg_data = dm_read_data;
            WRREG_PCPLUS:    write_reg_data = w_x3_pc;
        endcase
    end

    // ------------------------------------------------------------------
    // xREG4 : WB stage, doubles as the register-file write port
    // ------------------------------------------------------------------
    logic [c_x4_ctrl_w-1:0] w_x4_ctrl_in;
    logic [c_x4_data_w-1:0] w_x4_data_in;
    logic [c_x4_ctrl_w-1:0] w_x4_ctrl;
    logic [c_x4_data_w-1:0] w_x4_data;

    assign w_x4_ctrl_in = xREG3_do_reg_write;
    assign w_x4_data_in = {xREG3_write_reg_addr, write_reg_data};

    wb_stage_reg #(
        .CTRL_W (c_x4_ctrl_w),
        .DATA_W (c_x4_data_w)
    ) u_xreg4 (
        .clk      (clk),
        .rst      (rst),
        .i_hold   (w_freeze),
        .i_bubble (1'b0),
        .i_ctrl   (w_x4_ctrl_in),
        .i_data   (w_x4_data_in),
        .o_ctrl   (w_x4_ctrl),
        .o_data   (w_x4_data)
    );

    assign xREG4_do_reg_write = w_x4_ctrl[0];
    assign {xREG4_write_reg_addr, xREG4_write_reg_data} = w_x4_data;

    // ------------------------------------------------------------------
    // Hazard bubble counter, saturating at all-ones
    // ------------------------------------------------------------------
    logic [CW-1:0] r_hazard_cnt_q;
    logic [CW-1:0] w_hazard_cnt_d;

    // Next count: increment on a counted hazard unless already saturated
    always_comb begin
        w_hazard_cnt_d = r_hazard_cnt_q;
        if (w_hazard_inc && (r_hazard_cnt_q != {CW{1'b1}})) begin
            w_hazard_cnt_d = r_hazard_cnt_q + CW'(1);
        end
    end

    // Counter state, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hazard_cnt_q <= '0;
        end else begin
            r_hazard_cnt_q <= w_hazard_cnt_d;
        end
    end

    assign hazard_cnt = r_hazard_cnt_q;

endmodule
`default_nettype wire
